load_store_mem: RTL and testbench

LOAD_STORE_MEM -- requirements
Module: load_store_mem

---
 rtl/load_store_pkg.sv | 16 +
 rtl/load_store_ram.sv | 37 +++
 rtl/load_store_mem.sv | 185 ++++++++++++++++++
 tb/tb_load_store_mem.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_pkg.sv
// rtl/load_store_pkg.sv - shared enums for the load/store memory block
package load_store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/load_store_ram.sv
// rtl/load_store_ram.sv - word array with byte-lane write enables and registered read port
module load_store_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Contents are deliberately left unreset so data survives a block reset.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/load_store_mem.sv
// rtl/load_store_mem.sv - single-outstanding byte/half/word load-store port onto a local RAM
module load_store_mem
    import load_store_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        load_q, load_d;
    logic        fault_q, fault_d;
    logic [31:0] data_q, data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic          misaligned;
    logic          bad_size;
    logic          out_of_range;
    logic          req_fault;
    logic          accept;
    logic [AW-1:0] word_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          ram_re;
    logic [31:0]   ram_rdata;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    // Range check looks at every bit above the array so out-of-range never wraps onto a real word.
    always_comb begin
        misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        bad_size     = (req_size == 2'b11);
        out_of_range = (req_addr >> (AW + 2)) != '0;
        req_fault    = misaligned || bad_size || out_of_range;
        word_idx     = req_addr[AW+1:2];
        ram_re       = accept && !req_we && !req_fault;
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        if (accept && req_we && !req_fault) begin
            case (req_size)
                SZ_BYTE: begin
                    wr_be   = 4'b0001 << req_addr[1:0];
                    wr_data = {4{req_wdata[7:0]}};
                end
                SZ_HALF: begin
                    wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_data = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = data_q[7:0];
            2'd1:    ld_byte = data_q[15:8];
            2'd2:    ld_byte = data_q[23:16];
            default: ld_byte = data_q[31:24];
        endcase
        ld_half = off_q[1] ? data_q[31:16] : data_q[15:0];
        case (size_q)
            SZ_BYTE: ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = data_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        off_d       = off_q;
        uns_d       = uns_q;
        load_d      = load_q;
        fault_d     = fault_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    uns_d   = req_unsigned;
                    load_d  = !req_we;
                    fault_d = req_fault;
                    state_d = (!req_we && !req_fault) ? READ : RESP;
                end
            end
            READ: begin
                data_d  = ram_rdata;
                state_d = RESP;
            end
            RESP: begin
                // First RESP cycle loads the response registers; they then hold until consumed.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = fault_q;
                    rsp_rdata_d = (load_q && !fault_q) ? ld_data : 32'd0;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_fault_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
            load_q      <= 1'b0;
            fault_q     <= 1'b0;
            data_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
            load_q      <= load_d;
            fault_q     <= fault_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;

    load_store_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .addr (word_idx),
        .be   (wr_be),
        .wdata(wr_data),
        .re   (ram_re),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_load_store_mem.sv
// tb/tb_load_store_mem.sv - directed self-checking bench for load_store_mem
module tb_load_store_mem;

    localparam int DEPTH = 16;
    localparam int NB    = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    vec_t tbl [NB];

    always #5 clk = ~clk;

    load_store_mem #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_W     (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_fault   (rsp_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // One request from IDLE: checks latency, response values, optional stall, and return to IDLE.
    task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_fault, input int stall);
        int lat;
        lat = (!we && !exp_fault) ? 2 : 1;
        check({tag, ":ready"}, 32'(req_ready), 32'd1);
        drive(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < lat; k++) begin
            check({tag, ":early"}, 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, ":valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ":rdata"}, rsp_rdata, exp_rdata);
        check({tag, ":fault"}, 32'(rsp_fault), 32'(exp_fault));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ":hold_rdata"}, rsp_rdata, exp_rdata);
            check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ":done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ":done_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int idx;
        int n_rsp;
        logic acc;
        logic hs;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_fault", 32'(rsp_fault), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        txn("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        txn("st_b13", 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80, 32'h0, 1'b0, 0);
        txn("ld_b13s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        txn("ld_b13u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 0);
        txn("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 0);
        txn("ld_h12s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 0);
        txn("ld_h10u", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 0);
        txn("ld_b10s", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 0);
        txn("ld_b11u", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000BE, 1'b0, 0);

        txn("st_w00", 1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, 32'h0, 1'b0, 0);
        txn("st_h02", 1'b1, 2'b01, 1'b0, 32'h2, 32'hFFFF5566, 32'h0, 1'b0, 0);
        txn("ld_w00", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h55663344, 1'b0, 0);

        txn("flt_h11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 0);
        txn("flt_w12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 0);
        txn("flt_sz3", 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        txn("flt_oor", 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b1, 0);
        txn("keep_w00", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h55663344, 1'b0, 0);
        txn("keep_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 0);

        txn("stall", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 5);

        // Reset while the load sits in READ.
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        check("rdrst_valid", 32'(rsp_valid), 32'd0);
        check("rdrst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rdrst_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("rdrst_quiet", 32'(rsp_valid), 32'd0);
        txn("rdrst_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 0);

        // A store presented during reset must not land.
        rst_n = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
        #1;
        check("rstst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        txn("rstst_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 0);

        // Back-to-back stream with req_valid held and rsp_ready always high.
        tbl[0] = '{we: 1'b1, size: 2'b10, uns: 1'b0, addr: 32'h20, wdata: 32'h01020304, rdata: 32'h0,        fault: 1'b0};
        tbl[1] = '{we: 1'b1, size: 2'b10, uns: 1'b0, addr: 32'h24, wdata: 32'hA0B0C0D0, rdata: 32'h0,        fault: 1'b0};
        tbl[2] = '{we: 1'b0, size: 2'b10, uns: 1'b0, addr: 32'h20, wdata: 32'h0,        rdata: 32'h01020304, fault: 1'b0};
        tbl[3] = '{we: 1'b0, size: 2'b10, uns: 1'b0, addr: 32'h24, wdata: 32'h0,        rdata: 32'hA0B0C0D0, fault: 1'b0};
        tbl[4] = '{we: 1'b1, size: 2'b00, uns: 1'b0, addr: 32'h21, wdata: 32'h0000007F, rdata: 32'h0,        fault: 1'b0};
        tbl[5] = '{we: 1'b0, size: 2'b10, uns: 1'b0, addr: 32'h20, wdata: 32'h0,        rdata: 32'h01027F04, fault: 1'b0};
        tbl[6] = '{we: 1'b0, size: 2'b00, uns: 1'b0, addr: 32'h24, wdata: 32'h0,        rdata: 32'hFFFFFFD0, fault: 1'b0};
        tbl[7] = '{we: 1'b0, size: 2'b01, uns: 1'b1, addr: 32'h26, wdata: 32'h0,        rdata: 32'h0000A0B0, fault: 1'b0};
        tbl[8] = '{we: 1'b0, size: 2'b01, uns: 1'b0, addr: 32'h27, wdata: 32'h0,        rdata: 32'h0,        fault: 1'b1};

        idx   = 0;
        n_rsp = 0;
        rsp_ready = 1'b1;
        drive(tbl[0].we, tbl[0].size, tbl[0].uns, tbl[0].addr, tbl[0].wdata);
        #1;
        for (int cyc = 0; cyc < 200 && n_rsp < NB; cyc++) begin
            acc = req_valid && req_ready;
            hs  = rsp_valid && rsp_ready;
            if (hs) begin
                check($sformatf("b2b%0d_rdata", n_rsp), rsp_rdata, tbl[n_rsp].rdata);
                check($sformatf("b2b%0d_fault", n_rsp), 32'(rsp_fault), 32'(tbl[n_rsp].fault));
                n_rsp++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < NB) begin
                    drive(tbl[idx].we, tbl[idx].size, tbl[idx].uns, tbl[idx].addr, tbl[idx].wdata);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check("b2b_accepted", 32'(idx), 32'(NB));
        check("b2b_responses", 32'(n_rsp), 32'(NB));
        repeat (4) @(posedge clk);
        #1;
        check("b2b_no_extra", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
